// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared opcodes, parser states and PWM constants for led_stream_pwm
package led_pwm_pkg;

  localparam logic [2:0] OP_SET_DUTY  = 3'd0;
  localparam logic [2:0] OP_SET_ALL   = 3'd1;
  localparam logic [2:0] OP_SET_PRESC = 3'd2;

  // Last pwm_cnt value; a period is 0..PWM_TOP, i.e. 255 ticks
  localparam logic [7:0] PWM_TOP = 8'd254;

  typedef enum logic {
    IDLE  = 1'b0,
    VALUE = 1'b1
  } parse_state_e;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow/active duty pair and registered compare
module pwm_channel (
  input  logic       bus_clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       wrap,
  input  logic [7:0] pwm_cnt,
  output logic       led
);

  logic [7:0] shadow_q, shadow_d;
  logic [7:0] active_q, active_d;
  logic       led_q, led_d;

  // Shadow takes host writes at any time; active only copies it on the period wrap,
  // so a write landing on the wrap cycle is picked up one period later.
  always_comb begin
    shadow_d = wr ? wdata : shadow_q;
    active_d = wrap ? shadow_q : active_q;
    led_d    = (pwm_cnt < active_q);
  end

  // Duty registers and the output register
  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= 8'd0;
      active_q <= 8'd0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_stream_pwm.sv
// rtl/led_stream_pwm.sv - two-byte command parser driving double-buffered 8-bit LED PWM
module led_stream_pwm
  import led_pwm_pkg::*;
#(
  parameter int         NUM_LEDS  = 4,
  parameter logic [7:0] PRESC_RST = 8'd99
) (
  input  logic                bus_clk,
  input  logic                rst_n,
  input  logic                user_w_led_wren,
  input  logic [7:0]          user_w_led_data,
  input  logic                user_w_led_open,
  output logic                user_w_led_full,
  output logic [NUM_LEDS-1:0] led,
  output logic                cmd_err
);

  localparam logic [2:0] NUM_LEDS_W = 3'(NUM_LEDS);

  parse_state_e state_q, state_d;
  logic [2:0]   hdr_op_q, hdr_op_d;
  logic [1:0]   hdr_idx_q, hdr_idx_d;
  logic         err_q, err_d;
  logic         full_q, full_d;
  logic [7:0]   presc_q, presc_d;
  logic [7:0]   presc_cnt_q, presc_cnt_d;
  logic [7:0]   pwm_cnt_q, pwm_cnt_d;

  logic byte_in;
  logic exec;
  logic idx_ok;
  logic set_duty;
  logic set_all;
  logic set_presc;
  logic tick;
  logic wrap;

  // A closed device file masks the strobe entirely
  assign byte_in = user_w_led_open && user_w_led_wren;
  assign idx_ok  = ({1'b0, hdr_idx_q} < NUM_LEDS_W);

  // Parser state register
  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hdr_op_q  <= 3'd0;
      hdr_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      hdr_op_q  <= hdr_op_d;
      hdr_idx_q <= hdr_idx_d;
    end
  end

  // Parser next state: latch a header with bit 7 set, consume the value byte, drop on close
  always_comb begin
    state_d   = state_q;
    hdr_op_d  = hdr_op_q;
    hdr_idx_d = hdr_idx_q;
    if (!user_w_led_open) begin
      state_d = IDLE;
    end else if (user_w_led_wren) begin
      case (state_q)
        IDLE: begin
          if (user_w_led_data[7]) begin
            state_d   = VALUE;
            hdr_op_d  = user_w_led_data[6:4];
            hdr_idx_d = user_w_led_data[1:0];
          end
        end
        VALUE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Parser outputs: command execution strobes and protocol error
  always_comb begin
    exec      = byte_in && (state_q == VALUE);
    set_duty  = exec && (hdr_op_q == OP_SET_DUTY) && idx_ok;
    set_all   = exec && (hdr_op_q == OP_SET_ALL);
    set_presc = exec && (hdr_op_q == OP_SET_PRESC);
    err_d     = (byte_in && (state_q == IDLE) && !user_w_led_data[7]) ||
                (exec && (hdr_op_q == OP_SET_DUTY) && !idx_ok) ||
                (exec && (hdr_op_q > OP_SET_PRESC));
  end

  // Prescaler and period counter; a prescaler write restarts the prescale count
  always_comb begin
    tick        = (presc_cnt_q == presc_q);
    wrap        = tick && (pwm_cnt_q == PWM_TOP);
    full_d      = 1'b0;
    presc_d     = set_presc ? user_w_led_data : presc_q;
    presc_cnt_d = (set_presc || tick) ? 8'd0 : presc_cnt_q + 8'd1;
    pwm_cnt_d   = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = wrap ? 8'd0 : pwm_cnt_q + 8'd1;
    end
  end

  // Datapath and status registers
  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      full_q      <= 1'b1;
      presc_q     <= PRESC_RST;
      presc_cnt_q <= 8'd0;
      pwm_cnt_q   <= 8'd0;
    end else begin
      err_q       <= err_d;
      full_q      <= full_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = set_all || (set_duty && (hdr_idx_q == 2'(i)));

    pwm_channel u_ch (
      .bus_clk (bus_clk),
      .rst_n   (rst_n),
      .wr      (ch_wr),
      .wdata   (user_w_led_data),
      .wrap    (wrap),
      .pwm_cnt (pwm_cnt_q),
      .led     (led[i])
    );
  end

  assign cmd_err         = err_q;
  assign user_w_led_full = full_q;

endmodule

// File: tb/tb_led_stream_pwm.sv
// tb/tb_led_stream_pwm.sv - directed bench for led_stream_pwm with a cycle-level reference model
module tb_led_stream_pwm;

  localparam int NL = 4;

  logic          bus_clk = 1'b0;
  logic          rst_n;
  logic          wren;
  logic [7:0]    data;
  logic          open;
  logic          full;
  logic [NL-1:0] led;
  logic          cmd_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state (integers, follows the protocol rules directly)
  int            m_presc, m_pc, m_pwm;
  int            m_shadow[NL];
  int            m_active[NL];
  bit            m_in_value;
  int            m_op, m_idx;
  bit            m_err, m_full;
  logic [NL-1:0] m_led;

  always #5 bus_clk = ~bus_clk;

  led_stream_pwm #(.NUM_LEDS(NL), .PRESC_RST(8'd99)) dut (
    .bus_clk         (bus_clk),
    .rst_n           (rst_n),
    .user_w_led_wren (wren),
    .user_w_led_data (data),
    .user_w_led_open (open),
    .user_w_led_full (full),
    .led             (led),
    .cmd_err         (cmd_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  task automatic model_reset();
    m_presc = 99; m_pc = 0; m_pwm = 0;
    for (int i = 0; i < NL; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_in_value = 0; m_op = 0; m_idx = 0;
    m_err = 0; m_full = 1; m_led = '0;
  endtask

  // Advance the model across one rising edge with the inputs presented to it
  task automatic model_step(input logic w, input logic [7:0] d, input logic o);
    bit tick;
    bit wrap;
    int npc;
    int npwm;
    for (int i = 0; i < NL; i++) m_led[i] = (m_pwm < m_active[i]);
    tick = (m_pc == m_presc);
    wrap = tick && (m_pwm == 254);
    if (wrap) for (int i = 0; i < NL; i++) m_active[i] = m_shadow[i];
    npc  = tick ? 0 : m_pc + 1;
    npwm = tick ? ((m_pwm == 254) ? 0 : m_pwm + 1) : m_pwm;
    m_err  = 0;
    m_full = 0;
    if (!o) begin
      m_in_value = 0;
    end else if (w) begin
      if (!m_in_value) begin
        if (d[7]) begin
          m_in_value = 1;
          m_op  = int'(d[6:4]);
          m_idx = int'(d[1:0]);
        end else begin
          m_err = 1;
        end
      end else begin
        m_in_value = 0;
        case (m_op)
          0: if (m_idx < NL) m_shadow[m_idx] = int'(d); else m_err = 1;
          1: for (int i = 0; i < NL; i++) m_shadow[i] = int'(d);
          2: begin m_presc = int'(d); npc = 0; end
          default: m_err = 1;
        endcase
      end
    end
    m_pc  = npc;
    m_pwm = npwm;
  endtask

  // Every-cycle compare of all outputs against the model, away from the active edge
  initial begin
    model_reset();
    forever begin
      @(negedge bus_clk);
      if (!rst_n) model_reset();
      check("outputs{full,err,led}", {26'd0, full, cmd_err, led}, {26'd0, m_full, m_err, m_led});
      if (rst_n) model_step(wren, data, open);
    end
  end

  task automatic put(input logic [7:0] b);
    wren = 1'b1;
    data = b;
    @(posedge bus_clk); #2;
    wren = 1'b0;
  endtask

  // Returns just after the next predicted period-wrap edge
  task automatic wait_wrap();
    int n = 0;
    while (!(m_pc == m_presc && m_pwm == 254)) begin
      @(posedge bus_clk); #2;
      n++;
      if (n > 30000) begin
        timeout("wait_wrap");
        return;
      end
    end
    @(posedge bus_clk); #2;
  endtask

  task automatic measure(input int ch, input int n, output int c);
    c = 0;
    @(negedge bus_clk);
    for (int k = 0; k < n; k++) begin
      @(negedge bus_clk);
      if (led[ch]) c++;
    end
    @(posedge bus_clk); #2;
  endtask

  task automatic count_err(output int c);
    c = 0;
    repeat (4) begin
      @(negedge bus_clk);
      if (cmd_err) c++;
    end
    @(posedge bus_clk); #2;
  endtask

  initial begin
    int c;
    int a;
    int b;
    int n;
    rst_n = 1'b0;
    wren  = 1'b0;
    data  = 8'h80;
    open  = 1'b1;

    // Reset with the strobe toggling
    repeat (3) begin
      @(posedge bus_clk); #2;
      wren = ~wren;
    end
    @(negedge bus_clk);
    check("reset_full", full, 1);
    check("reset_led", led, 0);
    check("reset_err", cmd_err, 0);
    @(posedge bus_clk); #2;
    wren  = 1'b0;
    rst_n = 1'b1;
    @(posedge bus_clk); #2;
    check("full_after_release", full, 0);

    // Single duty at presc 0
    put(8'hA0); put(8'h00);
    put(8'h80); put(8'h40);
    wait_wrap();
    measure(0, 255, c); check("duty64_led0_count", c, 64);
    measure(1, 255, c); check("duty0_led1_count", c, 0);

    // Extremes via SET_ALL
    put(8'h90); put(8'hFF);
    wait_wrap();
    for (int i = 0; i < NL; i++) begin
      measure(i, 255, c);
      check("duty255_count", c, 255);
    end
    put(8'h90); put(8'h00);
    wait_wrap();
    for (int i = 0; i < NL; i++) begin
      measure(i, 255, c);
      check("duty0_count", c, 0);
    end

    // Protocol errors
    put(8'h05);
    count_err(c); check("bad_header_err_pulses", c, 1);
    put(8'hF0); put(8'h10);
    count_err(c); check("illegal_op_err_pulses", c, 1);

    // Open drop discards the pending header
    put(8'h81);
    open = 1'b0;
    @(posedge bus_clk); #2;
    open = 1'b1;
    put(8'h20);
    count_err(c); check("open_drop_err_pulses", c, 1);
    measure(1, 255, c); check("open_drop_led1_count", c, 0);

    // Prescaler 3 and a value byte landing exactly on the wrap edge
    put(8'hA0); put(8'h03);
    put(8'h82); put(8'h08);
    wait_wrap();
    n = 0;
    while (!(m_pwm == 254 && m_pc == m_presc - 1)) begin
      @(posedge bus_clk); #2;
      n++;
      if (n > 3000) begin
        timeout("wait_pre_wrap");
        break;
      end
    end
    put(8'h82);
    wren = 1'b1;
    data = 8'h40;
    @(posedge bus_clk); #2;
    wren = 1'b0;
    a = 0;
    b = 0;
    @(negedge bus_clk);
    for (int k = 0; k < 2040; k++) begin
      @(negedge bus_clk);
      if (led[2]) begin
        if (k < 1020) a++; else b++;
      end
    end
    @(posedge bus_clk); #2;
    check("race_old_duty_period", a, 32);
    check("race_new_duty_period", b, 256);

    // Asynchronous reset mid-period with LEDs on
    put(8'h90); put(8'hFF);
    wait_wrap();
    repeat (3) begin
      @(posedge bus_clk); #2;
    end
    check("all_on_before_reset", led, 4'hF);
    rst_n = 1'b0;
    #1;
    check("async_reset_led", led, 0);
    check("async_reset_full", full, 1);
    repeat (3) begin
      @(posedge bus_clk); #2;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge bus_clk); #2;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_stream_pwm.md
# led_stream_pwm

Consumes the 8-bit host-to-FPGA Xillybus write stream (the `/dev/xillybus_write_8` endpoint) and turns a two-byte command protocol into per-LED brightness. It drives the four `GPIO_LED` pins with 8-bit PWM, replacing direct latching of the raw data nibble. New duty values are double-buffered and take effect only at a PWM period boundary, so the LEDs never glitch.

## Interface

**Parameters**
- `NUM_LEDS`, default 4: number of PWM channels. Valid range 1..4, because the index field is 2 bits.
- `PRESC_RST`, default 8'd99: reset value of the prescaler.

**Ports**
- `bus_clk`, input, 1: the single clock for all logic.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `user_w_led_wren`, input, 1: byte strobe, one byte per cycle.
- `user_w_led_data`, input, 8: stream byte.
- `user_w_led_open`, input, 1: device file is open.
- `user_w_led_full`, output, 1: back-pressure to the stream.
- `led`, output, NUM_LEDS: PWM outputs, active high.
- `cmd_err`, output, 1: one-cycle pulse on a protocol error.

## Operation

**Command format**
- Every command is a header byte H followed by a value byte V.
- H[7] must be 1.
- H[6:4] is the opcode:
  - 0 = SET_DUTY: led H[1:0] gets duty V.
  - 1 = SET_ALL: every LED gets duty V.
  - 2 = SET_PRESC: prescaler becomes V.
  - 3..7 are illegal.
- H[3:2] is ignored.

**Parser FSM**
- States: IDLE, VALUE.
- In IDLE, a `wren` byte with bit 7 = 1 is latched as the header and the FSM moves to VALUE.
- In IDLE, a byte with bit 7 = 0 is discarded, `cmd_err` pulses, and the FSM stays in IDLE.
- In VALUE, any `wren` byte is taken as V. All 8 bits are significant, so bit 7 is not checked. The FSM then returns to IDLE and the command executes:
  - SET_DUTY with an index ≥ NUM_LEDS: `cmd_err` pulses and no write occurs.
  - Illegal opcode: `cmd_err` pulses and no write occurs.
- If `user_w_led_open` is 0, the FSM goes to IDLE and any partial header is discarded. A `wren` byte in the same cycle is ignored. Duty and prescaler values are retained.

**Shadow and active registers**
- SET_DUTY and SET_ALL write `shadow_duty[i]`.
- `active_duty[i]` is loaded from `shadow_duty[i]` for all channels simultaneously on the period-wrap cycle.
- SET_PRESC takes effect immediately: the prescale counter reloads to 0.

**PWM**
- The prescale counter counts 0..presc. A tick occurs when it equals presc, and it then wraps to 0.
- `pwm_cnt` counts 0..254 and advances on each tick. The period is 255 ticks.
- The period-wrap cycle is the tick cycle on which `pwm_cnt` = 254 goes to 0.
- Each output is `led[i] = (pwm_cnt < active_duty[i])`:
  - duty 0 gives constant off.
  - duty 255 gives constant on.
  - duty d is high for exactly d of the 255 ticks.
- `led` is registered.

**Back-pressure**
- `user_w_led_full` is 1 while in reset and 0 otherwise. The block accepts a byte every cycle.

## Timing

**Reset values**
- FSM = IDLE.
- All shadow and active duties = 0.
- presc = PRESC_RST; prescale counter = 0; `pwm_cnt` = 0.
- `led` = 0, `cmd_err` = 0, `full` = 1.

**Latencies**
- `cmd_err` is asserted in the cycle after the offending byte's `wren`.
- The shadow write is visible in the cycle after V's `wren`.
- `active_duty` updates at the next period wrap, between 1 and 255·(presc+1) cycles later.
- `led` reflects `active_duty` and `pwm_cnt` with one register stage.

**Boundary cases**
- V arriving in the same cycle as the wrap: the wrap loads the old shadow value, and the new value applies at the following wrap.
- Back-to-back commands with no idle cycle between them are accepted.
- Reset asserted mid-period or mid-command: all state returns to reset values immediately, asynchronously. `led` goes to 0.

## Structure

**Package `led_pwm_pkg`**
- Opcode constants: OP_SET_DUTY = 3'd0, OP_SET_ALL = 3'd1, OP_SET_PRESC = 3'd2.
- Parser state enum: IDLE, VALUE.
- PWM_TOP = 8'd254.

**Sub-module `pwm_channel`**
- Holds the shadow/active duty pair and the compare logic.
- Instantiated NUM_LEDS times.
- Inputs: `bus_clk`, `rst_n`, `wr`, `wdata`, `wrap`, `pwm_cnt`.
- Output: `led`.

**Top-level contents**
- Parser, prescaler and `pwm_cnt`.

## Test plan

1. **Reset:** hold `rst_n` = 0 with `wren` toggling → `led` = 0, `full` = 1, `cmd_err` = 0. After release, `full` = 0.
2. **Single duty:** with presc set to 0, send 0x80, 0x40 → `led[0]` is high for 64 of every 255 cycles, starting at the first wrap after the write. `led[1..3]` stay 0.
3. **Extremes:** send SET_ALL with 0xFF (0x90, 0xFF) → all LEDs constantly 1. Then send 0x90, 0x00 → all LEDs 0 from the next wrap, with no partial pulse.
4. **Errors:** send 0x05 in IDLE → `cmd_err` pulses once and the state is unchanged. Send 0xF0, 0x10 → `cmd_err` pulses and the duties are unchanged.
5. **Open drop:** send 0x81, deassert `open` for 1 cycle, then send 0x20 → 0x20 is treated as a bad header, so `cmd_err` pulses and `led[1]`'s duty is unchanged.
6. **Prescaler and wrap race:** send 0xA0, 0x03 → a tick every 4 cycles and a period of 1020 cycles. Place V exactly on the wrap cycle → the new duty applies one period later.
